// File: rtl/mcoi_gbt_reset_sequencer_if.sv
// Status/control bundle of the GBT reset sequencer: board-level inputs in,
// reset requests and sequencer status out.
interface mcoi_gbt_reset_sequencer_if;
    logic       pll_locked_i;
    logic       sfp_los_i;
    logic       force_reset_i;
    logic       pll_reset_o;
    logic       reset_o;
    logic       ready_o;
    logic [2:0] state_o;
    logic [7:0] los_count_o;

    modport master (
        output pll_locked_i, sfp_los_i, force_reset_i,
        input  pll_reset_o, reset_o, ready_o, state_o, los_count_o
    );

    modport slave (
        input  pll_locked_i, sfp_los_i, force_reset_i,
        output pll_reset_o, reset_o, ready_o, state_o, los_count_o
    );
endinterface

// File: rtl/mcoi_gbt_reset_sequencer.sv
// Board reset sequencer: PLL reset pulse, lock wait with retry, debounced SFP
// LOS, hold-off, then release of the system reset request.
module mcoi_gbt_reset_sequencer #(
    parameter int unsigned PLL_RST_CYCLES      = 16,
    parameter int unsigned LOCK_TIMEOUT_CYCLES = 1000000,
    parameter int unsigned LOS_FILTER_CYCLES   = 1000,
    parameter int unsigned HOLDOFF_CYCLES      = 4096
) (
    input  logic                        clk_ik,
    input  logic                        rst_ir,
    mcoi_gbt_reset_sequencer_if.slave   bus
);

    function automatic int unsigned max2(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

    localparam int unsigned MAX_PARAM = max2(max2(PLL_RST_CYCLES, LOCK_TIMEOUT_CYCLES),
                                             max2(LOS_FILTER_CYCLES, HOLDOFF_CYCLES));
    localparam int CNT_W = (MAX_PARAM > 1) ? $clog2(MAX_PARAM) : 1;
    localparam int FLT_W = (LOS_FILTER_CYCLES > 1) ? $clog2(LOS_FILTER_CYCLES) : 1;

    typedef enum logic [2:0] {
        PLLRST    = 3'd0,
        WAIT_LOCK = 3'd1,
        WAIT_LINK = 3'd2,
        HOLDOFF   = 3'd3,
        RUN       = 3'd4
    } state_t;

    logic [1:0]       lock_sync_q;
    logic [1:0]       los_sync_q;
    logic             lock_s;
    logic             los_s;

    logic [FLT_W-1:0] flt_cnt_q, flt_cnt_d;
    logic             los_filt_q, los_filt_d;
    logic             los_flip;
    logic             los_rise;
    logic [7:0]       los_count_q, los_count_d;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             pll_reset_q, reset_q, ready_q;

    assign lock_s = lock_sync_q[1];
    assign los_s  = los_sync_q[1];

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            lock_sync_q <= '0;
            los_sync_q  <= '0;
        end else begin
            lock_sync_q <= {lock_sync_q[0], bus.pll_locked_i};
            los_sync_q  <= {los_sync_q[0], bus.sfp_los_i};
        end
    end

    // Filtered LOS only moves after LOS_FILTER_CYCLES consecutive cycles of disagreement.
    assign los_flip = (los_s != los_filt_q) && (flt_cnt_q == FLT_W'(LOS_FILTER_CYCLES - 1));
    assign los_rise = los_flip && !los_filt_q;

    always_comb begin
        flt_cnt_d   = '0;
        los_filt_d  = los_filt_q;
        los_count_d = los_count_q;
        if (los_flip) begin
            los_filt_d = ~los_filt_q;
        end else if (los_s != los_filt_q) begin
            flt_cnt_d = flt_cnt_q + 1'b1;
        end
        if (los_rise && (los_count_q != 8'hFF)) begin
            los_count_d = los_count_q + 8'd1;
        end
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            flt_cnt_q   <= '0;
            los_filt_q  <= 1'b1;
            los_count_q <= '0;
        end else begin
            flt_cnt_q   <= flt_cnt_d;
            los_filt_q  <= los_filt_d;
            los_count_q <= los_count_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            PLLRST:    if (cnt_q == CNT_W'(PLL_RST_CYCLES - 1)) state_d = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s)                                          state_d = WAIT_LINK;
                else if (cnt_q == CNT_W'(LOCK_TIMEOUT_CYCLES - 1))   state_d = PLLRST;
            end
            WAIT_LINK: if (!los_filt_q) state_d = HOLDOFF;
            HOLDOFF:   if (cnt_q == CNT_W'(HOLDOFF_CYCLES - 1)) state_d = RUN;
            RUN:       state_d = RUN;
            default:   state_d = PLLRST;
        endcase

        if (bus.force_reset_i) begin
            state_d = PLLRST;
        end else if (!lock_s && (state_q == WAIT_LINK || state_q == HOLDOFF || state_q == RUN)) begin
            state_d = WAIT_LOCK;
        end else if (los_rise && (state_q == HOLDOFF || state_q == RUN)) begin
            state_d = WAIT_LINK;
        end

        // Force also restarts the count when already sitting in PLLRST.
        if ((state_d != state_q) || bus.force_reset_i) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_ik or posedge rst_ir) begin
        if (rst_ir) begin
            state_q     <= PLLRST;
            cnt_q       <= '0;
            pll_reset_q <= 1'b1;
            reset_q     <= 1'b1;
            ready_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            pll_reset_q <= (state_d == PLLRST);
            reset_q     <= (state_d != RUN);
            ready_q     <= (state_d == RUN);
        end
    end

    assign bus.pll_reset_o = pll_reset_q;
    assign bus.reset_o     = reset_q;
    assign bus.ready_o     = ready_q;
    assign bus.state_o     = state_q;
    assign bus.los_count_o = los_count_q;

endmodule

// File: doc/mcoi_gbt_reset_sequencer.md
Name: mcoi_gbt_reset_sequencer

Overview:
- Generates the system reset request that feeds the board clock/reset tree, replacing the direct use of SFP loss-of-signal as reset.
- Sequences bring-up in order: PLL reset pulse, wait for PLL lock with a timeout and retry, debounce SFP LOS, then a hold-off count before releasing reset.
- Downstream reset synchronisers consume reset_o in each clock domain.
- Runs in the free-running 100MHz domain.

Parameters:
- PLL_RST_CYCLES, 16: cycles pll_reset_o is held high per PLL reset attempt.
- LOCK_TIMEOUT_CYCLES, 1000000: cycles in WAIT_LOCK before a PLL reset retry.
- LOS_FILTER_CYCLES, 1000: consecutive stable cycles required before the filtered LOS changes value.
- HOLDOFF_CYCLES, 4096: cycles spent in HOLDOFF before RUN.

Ports:
- clk_ik  in  1  Block clock, 100MHz domain.
- rst_ir  in  1  Reset, asynchronous, active-high.
- pll_locked_i  in  1  PLL lock, asynchronous. Passed through a 2-FF synchroniser.
- sfp_los_i  in  1  SFP loss of signal, asynchronous, 1 = no link. Passed through a 2-FF synchroniser.
- force_reset_i  in  1  Synchronous level, 1 = restart the sequence.
- pll_reset_o  out  1  PLL reset, registered.
- reset_o  out  1  System reset request, registered.
- ready_o  out  1  1 only in RUN, registered.
- state_o  out  3  Current state encoding.
- los_count_o  out  8  Count of accepted LOS assertions, saturating.

Behaviour:
- Interface: one clock (clk_ik); reset rst_ir is asynchronous and active-high.
- All flops, including the synchronisers, clear asynchronously on rst_ir.
- Reset values: pll_reset_o=1, reset_o=1, ready_o=0, state_o=0 (PLLRST), los_count_o=0, filtered LOS=1, shared counter=0.
- Synchroniser latency: 2 cycles. All timing below refers to the synchronised signals.
- LOS filter:
  - A separate counter increments while sync LOS differs from filtered LOS, and clears when they are equal.
  - On reaching LOS_FILTER_CYCLES-1, the filtered LOS flips and the filter counter clears.
  - Glitches shorter than LOS_FILTER_CYCLES are ignored.
- los_count_o increments on each filtered-LOS 0->1 transition and saturates at 255.
- Shared counter: one counter, cleared on every state transition, incremented otherwise. Width = clog2 of the largest parameter.
- States: PLLRST=0, WAIT_LOCK=1, WAIT_LINK=2, HOLDOFF=3, RUN=4. Other codes go to PLLRST.
  - PLLRST: pll_reset_o=1. Leave after exactly PLL_RST_CYCLES cycles -> WAIT_LOCK.
  - WAIT_LOCK: on lock -> WAIT_LINK. If the counter reaches LOCK_TIMEOUT_CYCLES-1 without lock -> PLLRST (retry).
  - WAIT_LINK: on filtered LOS=0 -> HOLDOFF.
  - HOLDOFF: after exactly HOLDOFF_CYCLES cycles -> RUN.
  - RUN: stays until an event below.
- Events, highest priority first:
  1. force_reset_i=1 in any state -> PLLRST next cycle, counter cleared.
  2. Lock loss in WAIT_LINK, HOLDOFF or RUN -> WAIT_LOCK.
  3. Filtered LOS rising in HOLDOFF or RUN -> WAIT_LINK.
- Simultaneous lock loss and LOS rise: the state goes to WAIT_LOCK; los_count_o still increments.
- Outputs are registered from the next state:
  - reset_o = (next != RUN).
  - ready_o = (next == RUN).
  - pll_reset_o = (next == PLLRST).
  - state_o therefore changes on the same edge as reset_o and ready_o.
- Asynchronous rst_ir mid-sequence: outputs take reset values immediately without a clock edge. The sequence restarts at PLLRST on the first edge after release.

Test Plan (params PLL_RST=4, TIMEOUT=32, LOS_FILTER=4, HOLDOFF=8):
1. Nominal bring-up: lock=1 and LOS=0 held from reset release.
   - Required: pll_reset_o high for 4 cycles, then WAIT_LOCK, WAIT_LINK until filtered LOS clears after 4 stable cycles, 8 cycles of HOLDOFF, then RUN.
   - In RUN: reset_o=0, ready_o=1, state_o=4, los_count_o=0.
2. LOS glitches in RUN:
   - A 3-cycle LOS pulse -> state stays 4, los_count_o=0.
   - A 5-cycle LOS pulse -> state goes to 2, reset_o=1, los_count_o=1.
   - After LOS clears -> HOLDOFF, then RUN again.
3. Lock never asserts:
   - Required: pll_reset_o pulses 4 cycles high every 4+32 cycles.
   - ready_o stays 0; state cycles 0->1->0.
4. Lock loss for 1 cycle in HOLDOFF cycle 5 -> state 1 after the sync delay. On lock return -> WAIT_LINK; HOLDOFF then restarts with a full 8 cycles.
5. force_reset_i pulsed 1 cycle in RUN:
   - Required: state_o=0 and pll_reset_o=1 on the next edge; full sequence repeats.
   - force_reset_i asserted together with an LOS rise -> PLLRST, with los_count_o still incremented.
6. rst_ir asserted asynchronously mid-HOLDOFF:
   - Required: outputs at reset values before the next clk_ik edge.
   - Separately, 300 accepted LOS events -> los_count_o=255.
